ir_seq: RTL and testbench

IR_SEQ -- requirements
Module: ir_seq

---
 rtl/ir_seq_if.sv | 11 +
 rtl/ir_seq.sv | 183 ++++++++++++++++++
 tb/tb_ir_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ir_seq_if.sv
// Downstream operation-issue bus of the IR sequencer: valid/ready handshake
// carrying a 4-bit opcode and a 24-bit operand.
interface ir_seq_if;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [23:0] op_arg;
  logic        op_ready;

  modport master (output op_valid, op_code, op_arg, input op_ready);
  modport slave  (input op_valid, op_code, op_arg, output op_ready);
endinterface

// File: rtl/ir_seq.sv
// IR sequencer: fetches 32-bit instruction words from a 32-entry register file
// and executes NOP/EXEC/WAIT/JMP/LOOP/END, issuing EXEC ops over a handshake bus.
module ir_seq #(
  parameter int START_PC = 0,
  parameter int WAIT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  pc_sel,
  input  logic [31:0] pcdata,
  ir_seq_if.master    op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    C_NOP  = 4'h0,
    C_EXEC = 4'h1,
    C_WAIT = 4'h2,
    C_JMP  = 4'h3,
    C_LOOP = 4'h4,
    C_END  = 4'hF
  } cls_t;

  localparam logic [4:0] START_PC5 = START_PC[4:0];

  state_t            state;
  logic [4:0]        pc;
  logic [31:0]       instr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        loop_cnt;
  logic              loop_act;
  logic              err_q;
  logic              op_valid_q;

  // Instruction field views
  logic [3:0]        cls;
  logic [4:0]        target;
  logic [7:0]        loop_count;
  logic [WAIT_W-1:0] wait_arg;
  logic              loop_exit;
  logic              advance;

  assign cls        = instr[31:28];
  assign target     = instr[4:0];
  assign loop_count = instr[15:8];
  assign wait_arg   = instr[WAIT_W-1:0];

  // A LOOP falls through once its repeat count is exhausted (or was zero).
  assign loop_exit = loop_act ? (loop_cnt <= 8'd1) : (loop_count == 8'd0);

  // advance: this cycle needs pc <= pc+1 (which may overflow at pc = 31).
  always_comb begin
    // NOTE: default first so no path leaves advance unassigned (no latch).
    advance = 1'b0;
    case (state)
      S_DECODE: begin
        case (cls)
          C_NOP:   advance = 1'b1;
          C_WAIT:  advance = (wait_arg == '0);
          C_LOOP:  advance = loop_exit;
          default: advance = 1'b0;
        endcase
      end
      S_ISSUE: advance = op_valid_q && op.op_ready;
      S_WAIT:  advance = (wait_cnt == WAIT_W'(1));
      default: advance = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= START_PC5;
      instr      <= '0;
      wait_cnt   <= '0;
      loop_cnt   <= '0;
      loop_act   <= 1'b0;
      err_q      <= 1'b0;
      op_valid_q <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      op_valid_q <= 1'b0;
      loop_act   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc       <= START_PC5;
            err_q    <= 1'b0;
            loop_act <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          instr <= pcdata;
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (cls)
            C_NOP: ;
            C_EXEC: begin
              op_valid_q <= 1'b1;
              state      <= S_ISSUE;
            end
            C_WAIT: begin
              if (wait_arg != '0) begin
                wait_cnt <= wait_arg;
                state    <= S_WAIT;
              end
            end
            C_JMP: begin
              pc    <= target;
              state <= S_FETCH;
            end
            C_LOOP: begin
              if (loop_act) begin
                if (!loop_exit) begin
                  loop_cnt <= loop_cnt - 8'd1;
                  pc       <= target;
                  state    <= S_FETCH;
                end else begin
                  loop_act <= 1'b0;
                end
              end else begin
                loop_cnt <= loop_count;
                if (!loop_exit) begin
                  loop_act <= 1'b1;
                  pc       <= target;
                  state    <= S_FETCH;
                end
              end
            end
            C_END:   state <= S_DONE;
            default: begin
              err_q <= 1'b1;
              state <= S_DONE;
            end
          endcase
        end
        S_ISSUE: begin
          if (advance) op_valid_q <= 1'b0;
        end
        S_WAIT:  wait_cnt <= wait_cnt - WAIT_W'(1);
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // NOTE: placed last so its state/pc assignments win over the case above.
      if (advance) begin
        if (pc == 5'd31) begin
          err_q <= 1'b1;
          state <= S_DONE;
        end else begin
          pc    <= pc + 5'd1;
          state <= S_FETCH;
        end
      end
    end
  end

  assign pc_sel      = {3'b000, pc};
  assign op.op_valid = op_valid_q;
  assign op.op_code  = instr[27:24];
  assign op.op_arg   = instr[23:0];
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_ir_seq.sv
// Self-checking bench for ir_seq: small programs in a modelled IR file, with a
// scoreboard of expected EXEC ops compared at each handshake.
module tb_ir_seq;
  localparam int START_PC = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  pc_sel;
  logic [31:0] pcdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] ir_mem [32];

  typedef struct packed {
    logic [3:0]  code;
    logic [23:0] arg;
  } op_t;

  op_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  ir_seq_if op_bus ();

  ir_seq #(.START_PC(START_PC), .WAIT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .pc_sel (pc_sel),
    .pcdata (pcdata),
    .op     (op_bus),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  assign pcdata = ir_mem[pc_sel[4:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_ir();
    for (int i = 0; i < 32; i++) ir_mem[i] = 32'h0000_0000;
  endtask

  task automatic push_op(input logic [3:0] code, input logic [23:0] arg);
    op_t e;
    e.code = code;
    e.arg  = arg;
    exp_q.push_back(e);
  endtask

  // Pulse start, then observe one cycle per iteration until the sequencer is idle.
  task automatic run_prog(input int budget, input bit rand_ready, input int restart_at,
                          output int done_at, output int busy_cnt, output int done_cnt,
                          output int hs_cnt, output bit err_start);
    logic [3:0]  prev_code;
    logic [23:0] prev_arg;
    bit          prev_stall;
    bit          finished;
    op_t         e;
    done_at = -1; busy_cnt = 0; done_cnt = 0; hs_cnt = 0;
    prev_stall = 1'b0; finished = 1'b0;
    prev_code = '0; prev_arg = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    err_start = err;
    for (int c = 0; c < budget && !finished; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == restart_at);
      if (rand_ready) op_bus.op_ready = 1'($urandom_range(0, 1));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (prev_stall) begin
        check("op_valid_hold", 32'(op_bus.op_valid), 32'd1);
        check("op_code_hold", 32'(op_bus.op_code), 32'(prev_code));
        check("op_arg_hold", 32'(op_bus.op_arg), 32'(prev_arg));
      end
      if (op_bus.op_valid && op_bus.op_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("op_extra", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("op_code", 32'(op_bus.op_code), 32'(e.code));
          check("op_arg", 32'(op_bus.op_arg), 32'(e.arg));
        end
      end
      prev_stall = op_bus.op_valid && !op_bus.op_ready;
      prev_code  = op_bus.op_code;
      prev_arg   = op_bus.op_arg;
      if (!busy) finished = 1'b1;
    end
    start = 1'b0;
    check("run_finished", 32'(finished), 32'd1);
    check("sb_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  int d_at, b_cnt, d_cnt, h_cnt;
  bit e_st;
  bit seen;

  initial begin
    start = 1'b0;
    abort = 1'b0;
    op_bus.op_ready = 1'b0;
    clear_ir();

    // Reset, with start and abort asserted to show rst overrides them
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_op_valid", 32'(op_bus.op_valid), 32'd0);
    check("rst_pc_sel", 32'(pc_sel), 32'(START_PC));
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;

    // Single EXEC then END
    clear_ir();
    ir_mem[0] = 32'h1A00_0055;
    ir_mem[1] = 32'hF000_0000;
    op_bus.op_ready = 1'b1;
    push_op(4'hA, 24'h00_0055);
    run_prog(40, 1'b0, -1, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("exec_done_at", d_at, 32'd5);
    check("exec_hs", h_cnt, 32'd1);
    check("exec_done_cnt", d_cnt, 32'd1);
    check("exec_busy", b_cnt, 32'd6);
    check("exec_err", 32'(err), 32'd0);

    // WAIT 3 then END
    clear_ir();
    ir_mem[0] = 32'h2000_0003;
    ir_mem[1] = 32'hF000_0000;
    run_prog(40, 1'b0, -1, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("wait_busy", b_cnt, 32'd8);
    check("wait_done_cnt", d_cnt, 32'd1);
    check("wait_done_at", d_at, 32'd7);
    check("wait_hs", h_cnt, 32'd0);

    // EXEC inside LOOP count 2: body runs three times
    clear_ir();
    ir_mem[0] = 32'h13AB_CDEF;
    ir_mem[1] = 32'h4000_0200;
    ir_mem[2] = 32'hF000_0000;
    for (int i = 0; i < 3; i++) push_op(4'h3, 24'hAB_CDEF);
    run_prog(80, 1'b0, -1, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("loop_hs", h_cnt, 32'd3);
    check("loop_busy", b_cnt, 32'd18);
    check("loop_done_cnt", d_cnt, 32'd1);
    check("loop_err", 32'(err), 32'd0);

    // Illegal class sets err with done; next start clears it
    clear_ir();
    ir_mem[0] = 32'h7000_0000;
    run_prog(20, 1'b0, -1, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("ill_done_at", d_at, 32'd2);
    check("ill_done_cnt", d_cnt, 32'd1);
    check("ill_err", 32'(err), 32'd1);
    ir_mem[0] = 32'hF000_0000;
    @(negedge clk);
    check("ill_err_hold", 32'(err), 32'd1);
    run_prog(20, 1'b0, -1, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("ill_err_clr_start", 32'(e_st), 32'd0);
    check("ill_err_clr_end", 32'(err), 32'd0);
    check("end_done_at", d_at, 32'd2);

    // Abort during a stalled ISSUE
    clear_ir();
    ir_mem[0] = 32'h1500_1234;
    ir_mem[1] = 32'hF000_0000;
    op_bus.op_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (op_bus.op_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("abort_issue_reached", 32'(seen), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("abort_stall_valid", 32'(op_bus.op_valid), 32'd1);
      check("abort_stall_code", 32'(op_bus.op_code), 32'h5);
      check("abort_stall_arg", 32'(op_bus.op_arg), 32'h00_1234);
    end
    abort = 1'b1;
    start = 1'b1;
    op_bus.op_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    op_bus.op_ready = 1'b0;
    check("abort_op_valid", 32'(op_bus.op_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) begin
      check("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    op_bus.op_ready = 1'b1;
    push_op(4'h5, 24'h00_1234);
    run_prog(40, 1'b0, -1, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("abort_rerun_done_at", d_at, 32'd5);
    check("abort_rerun_hs", h_cnt, 32'd1);

    // All NOPs: overflow at pc 31; a start mid-run is ignored
    clear_ir();
    run_prog(200, 1'b0, 10, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("nop_busy", b_cnt, 32'd65);
    check("nop_done_at", d_at, 32'd64);
    check("nop_done_cnt", d_cnt, 32'd1);
    check("nop_err", 32'(err), 32'd1);

    // Reset mid-WAIT with start/abort also asserted
    clear_ir();
    ir_mem[0] = 32'h2000_0064;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rstw_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_err", 32'(err), 32'd0);
    check("rstw_pc_sel", 32'(pc_sel), 32'(START_PC));
    check("rstw_done", 32'(done), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstw_stay_idle", 32'(busy), 32'd0);
    end

    // JMP then WAIT 0 then EXEC with a random op_ready
    clear_ir();
    ir_mem[0] = 32'h3000_0005;
    ir_mem[5] = 32'h2000_0000;
    ir_mem[6] = 32'h1F00_0777;
    ir_mem[7] = 32'hF000_0000;
    push_op(4'hF, 24'h00_0777);
    run_prog(200, 1'b1, -1, d_at, b_cnt, d_cnt, h_cnt, e_st);
    check("jmp_hs", h_cnt, 32'd1);
    check("jmp_done_cnt", d_cnt, 32'd1);
    check("jmp_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
